add_sub_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor for two's-complement and unsigned operands of WIDTH bits. It processes DIGIT bits per clock, starting from the LSB slice, and carries the ripple carry between slices in a register. It produces the result plus carry, overflow, zero and negative flags. It sits behind a valid/ready handshake on both sides, so datapath sequencers can use it as a small arithmetic unit that trades area for latency.

---
 rtl/add_sub_if.sv | 29 ++
 rtl/add_sub_seq.sv | 108 ++++++++++
 tb/tb_add_sub_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/add_sub_if.sv
// Valid/ready request and response bundle for the sequential adder/subtractor.
// The master drives operands and out_ready. The slave returns the result, the flags and busy.
interface add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n, busy
  );
endinterface

// File: rtl/add_sub_seq.sv
// Digit-serial adder/subtractor: DIGIT bits per clock from the LSB slice upward, with a registered ripple carry.
// Partial sums collect in a work register, so the visible result changes only when an operation completes.
module add_sub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  add_sub_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // RUN   | one DIGIT-wide slice added per cycle
  // DONE  | result/flags presented until out_ready
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CW-1:0]    cnt;

  int               idx;
  logic [DIGIT-1:0] a_s;
  logic [DIGIT-1:0] b_s;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] next_work;
  logic             msb_cin;

  always_comb begin
    idx       = 0;
    a_s       = '0;
    b_s       = '0;
    sum       = '0;
    next_work = work;
    msb_cin   = 1'b0;
    idx       = int'(cnt) * DIGIT;
    a_s       = a_reg[idx +: DIGIT];
    b_s       = b_reg[idx +: DIGIT];
    sum       = {1'b0, a_s} + {1'b0, b_s} + {{DIGIT{1'b0}}, carry};
    next_work[idx +: DIGIT] = sum[DIGIT-1:0];
    // The carry into the MSB is recovered from the MSB sum bit.
    // This avoids a second adder for the lower DIGIT-1 bits.
    msb_cin   = next_work[WIDTH-1] ^ a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      work          <= '0;
      carry         <= 1'b0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.result    <= '0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.op_a;
            b_reg        <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry        <= bus.op_sub;
            cnt          <= '0;
            work         <= '0;
            state        <= RUN;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        RUN: begin
          work  <= next_work;
          carry <= sum[DIGIT];
          if (cnt == CW'(STEPS - 1)) begin
            bus.result    <= next_work;
            bus.flag_c    <= sum[DIGIT];
            bus.flag_v    <= msb_cin ^ sum[DIGIT];
            bus.flag_z    <= (next_work == '0);
            bus.flag_n    <= next_work[WIDTH-1];
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq with three instances: 16/4, 8/1 and 8/8.
// A reference model pushes each expected result onto a queue, which is popped when out_valid appears.
module tb_add_sub_seq;
  typedef struct packed {
    logic [15:0] res;
    logic c, v, z, n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        go = 1'b0, rdy = 1'b0, sub = 1'b0;
  logic [15:0] opa = '0, opb = '0;
  int          n_vec = 0, n_bad = 0;
  exp_t        q[$];
  exp_t        last;

  add_sub_if #(.WIDTH(16)) bus16 ();
  add_sub_if #(.WIDTH(8))  bus81 ();
  add_sub_if #(.WIDTH(8))  bus88 ();

  add_sub_seq #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  add_sub_seq #(.WIDTH(8),  .DIGIT(1)) u81 (.clk(clk), .rst(rst), .bus(bus81.slave));
  add_sub_seq #(.WIDTH(8),  .DIGIT(8)) u88 (.clk(clk), .rst(rst), .bus(bus88.slave));

  assign bus16.in_valid = go && sel == 0;
  assign bus81.in_valid = go && sel == 1;
  assign bus88.in_valid = go && sel == 2;
  assign bus16.out_ready = rdy && sel == 0;
  assign bus81.out_ready = rdy && sel == 1;
  assign bus88.out_ready = rdy && sel == 2;
  assign bus16.op_a = opa;
  assign bus16.op_b = opb;
  assign bus16.op_sub = sub;
  assign bus81.op_a = opa[7:0];
  assign bus81.op_b = opb[7:0];
  assign bus81.op_sub = sub;
  assign bus88.op_a = opa[7:0];
  assign bus88.op_b = opb[7:0];
  assign bus88.op_sub = sub;

  logic        g_ir, g_ov, g_busy;
  exp_t        g;
  always_comb begin
    g_ir = 1'b0; g_ov = 1'b0; g_busy = 1'b0; g = '0;
    case (sel)
      0: begin
        g_ir = bus16.in_ready; g_ov = bus16.out_valid; g_busy = bus16.busy;
        g = '{bus16.result, bus16.flag_c, bus16.flag_v, bus16.flag_z, bus16.flag_n};
      end
      1: begin
        g_ir = bus81.in_ready; g_ov = bus81.out_valid; g_busy = bus81.busy;
        g = '{{8'h00, bus81.result}, bus81.flag_c, bus81.flag_v, bus81.flag_z, bus81.flag_n};
      end
      default: begin
        g_ir = bus88.in_ready; g_ov = bus88.out_valid; g_busy = bus88.busy;
        g = '{{8'h00, bus88.result}, bus88.flag_c, bus88.flag_v, bus88.flag_z, bus88.flag_n};
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    logic [32:0] m, aa, bb, full, lo;
    m    = (33'd1 << w) - 33'd1;
    aa   = {17'd0, a} & m;
    bb   = s ? (~{17'd0, b}) & m : {17'd0, b} & m;
    full = aa + bb + 33'(s);
    lo   = (aa & (m >> 1)) + (bb & (m >> 1)) + 33'(s);
    e.res = full[15:0] & m[15:0];
    e.c   = full[w];
    e.v   = lo[w-1] ^ full[w];
    e.z   = (full & m) == 33'd0;
    e.n   = full[w-1];
    return e;
  endfunction

  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic sb, input int hold);
    int   steps, w, lat;
    exp_t e;
    steps = (s == 0) ? 4 : (s == 1) ? 8 : 1;
    w     = (s == 0) ? 16 : 8;
    @(negedge clk);
    sel = s;
    lat = 0;
    while (!g_ir && lat < 50) begin @(negedge clk); lat++; end
    chk("in_ready_before", 32'(g_ir), 32'd1);
    opa = a; opb = b; sub = sb; go = 1'b1;
    q.push_back(model(w, a, b, sb));
    @(posedge clk); #1;
    go = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!g_ov && (g_ir !== 1'b0 || g_busy !== 1'b1)) chk("run_hs", {30'd0, g_ir, g_busy}, 32'd1);
    end while (!g_ov && lat < 50);
    chk("latency", 32'(lat), 32'(steps));
    e = q.pop_front();
    chk("result", 32'(g), 32'(e));
    last = g;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      opa = 16'($urandom); opb = 16'($urandom); sub = 1'($urandom); go = 1'b1;
      @(posedge clk); #1;
      chk("hold_state", {29'd0, g_ov, g_ir, g_busy}, 32'b101);
      chk("hold_result", 32'(g), 32'(e));
    end
    @(negedge clk);
    go = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("release", {29'd0, g_ov, g_ir, g_busy}, 32'b010);
    @(negedge clk);
    rdy = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {29'd0, bus16.out_valid, bus16.in_ready, bus16.busy}, 32'b010);
    chk("reset_result", {12'd0, bus16.result, bus16.flag_c, bus16.flag_v, bus16.flag_z, bus16.flag_n}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 16'h1234, 16'h0FFF, 1'b0, 0);
    chk("plan_add", 32'(last), 32'({16'h2233, 4'b0000}));
    run_op(0, 16'h0005, 16'h0007, 1'b1, 0);
    chk("plan_sub_borrow", 32'(last), 32'({16'hFFFE, 4'b0001}));
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 0);
    chk("plan_ovf", 32'(last), 32'({16'h8000, 4'b0101}));
    run_op(0, 16'h1234, 16'h1234, 1'b1, 3);
    chk("plan_zero", 32'(last), 32'({16'h0000, 4'b1010}));

    // Reset is asserted in the second RUN cycle.
    @(negedge clk);
    sel = 0; opa = 16'hAAAA; opb = 16'h1111; sub = 1'b0; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", {29'd0, g_ov, g_ir, g_busy}, 32'b010);
    chk("abort_result", 32'(g), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 0);
    chk("plan_after_abort", 32'(last), 32'({16'h0100, 4'b0000}));

    run_op(1, 16'h0080, 16'h0001, 1'b1, 0);
    chk("plan_w8d1", 32'(last), 32'({16'h007F, 4'b1100}));
    run_op(2, 16'h00FF, 16'h0001, 1'b0, 1);
    chk("plan_w8d8", 32'(last), 32'({16'h0000, 4'b1010}));

    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 8; k++)
        run_op(s, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
